// File: rtl/bcd_conv_sched.sv
// Shared round-robin binary-to-BCD converter; double-dabble, one bit per clock. Optional macro BCD_SCHED_BLANK_EN adds leading-zero blanking.
// Latency: grant edge E, ack and bcd_out registered at E+B_SIZE+1; next grant no earlier than E+B_SIZE+2.
// Backpressure: requesters hold req until their ack; one conversion in flight, others wait without loss.
module bcd_conv_sched #(
    parameter int B_SIZE = 12,
    parameter int N_REQ  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*B_SIZE-1:0]   bin_in,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    output logic [N_REQ-1:0]          ack,
    output logic [B_SIZE+3:0]         bcd_out
);

    localparam int BW = B_SIZE + 4;          // BCD field width
    localparam int ND = BW / 4;              // number of BCD digits
    localparam int SW = BW + B_SIZE;         // {bcd, bin} shift register width
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(B_SIZE + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic [SW-1:0]      sh_q, sh_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      last_q, last_d;

    logic [N_REQ-1:0]   eff;
    logic [IW:0]        cand;
    logic               pick_vld;
    logic [IW-1:0]      pick_idx;
    logic [N_REQ-1:0]   pick_oh;
    logic [B_SIZE-1:0]  pick_bin;
    logic [SW-1:0]      adj;
    logic [BW-1:0]      final_bcd;
`ifdef BCD_SCHED_BLANK_EN
    logic               seen_nz;
`endif

    // Round-robin pick: first effective request searching upward from last+1, wrapping.
    always_comb begin
        eff      = req & ~ack_q;
        cand     = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!pick_vld && eff[cand[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IW-1:0];
            end
        end
    end

    // Decode the winner into a one-hot grant and select its binary operand.
    always_comb begin
        pick_oh  = '0;
        pick_bin = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_oh[i] = 1'b1;
                pick_bin   = bin_in[i*B_SIZE +: B_SIZE];
            end
        end
    end

    // Add-3 correction on every BCD digit above 4, ahead of the shift.
    always_comb begin
        adj = sh_q;
        for (int d = 0; d < ND; d++) begin
            if (sh_q[B_SIZE + 4*d +: 4] > 4'd4) begin
                adj[B_SIZE + 4*d +: 4] = sh_q[B_SIZE + 4*d +: 4] + 4'd3;
            end
        end
    end

    // Result presented at the DONE edge, with optional leading-zero blanking (digit 0 never blanked).
    always_comb begin
        final_bcd = sh_q[SW-1:B_SIZE];
`ifdef BCD_SCHED_BLANK_EN
        seen_nz = 1'b0;
        for (int d = ND - 1; d >= 1; d--) begin
            if (final_bcd[4*d +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            if (!seen_nz) begin
                final_bcd[4*d +: 4] = 4'hF;
            end
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: grant when idle, B_SIZE shifts, one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_vld) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CW'(B_SIZE - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and datapath next values per state.
    always_comb begin
        grant_d = grant_q;
        busy_d  = busy_q;
        ack_d   = '0;
        bcd_d   = bcd_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_oh;
                    busy_d  = 1'b1;
                    sh_d    = {{BW{1'b0}}, pick_bin};
                    cnt_d   = '0;
                    last_d  = pick_idx;
                end
            end
            S_SHIFT: begin
                sh_d  = adj << 1;
                cnt_d = cnt_q + CW'(1);
            end
            S_DONE: begin
                bcd_d   = final_bcd;
                ack_d   = grant_q;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset discards any in-flight conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            bcd_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
        end else begin
            grant_q <= grant_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            bcd_q   <= bcd_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign ack     = ack_q;
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
module tb_bcd_conv_sched;

    localparam int B  = 12;
    localparam int N  = 2;
    localparam int BW = B + 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*B-1:0]  bin_in;
    logic [N-1:0]    grant;
    logic            busy;
    logic [N-1:0]    ack;
    logic [BW-1:0]   bcd_out;

    int n_checks = 0;
    int n_errors = 0;
    int model_last;

    always #5 clk = ~clk;

    bcd_conv_sched #(.B_SIZE(B), .N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in),
        .grant(grant), .busy(busy), .ack(ack), .bcd_out(bcd_out)
    );

    // Reference: decimal digits by division, blanking by counting significant digits.
    function automatic logic [BW-1:0] model_bcd(input int v);
        logic [BW-1:0] r;
        int x, ndig, t;
        r = '0;
        x = v;
        for (int d = 0; d < BW/4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BCD_SCHED_BLANK_EN
        ndig = 1;
        t = v;
        while (t >= 10) begin
            t = t / 10;
            ndig++;
        end
        for (int d = ndig; d < BW/4; d++) r[4*d +: 4] = 4'hF;
`else
        ndig = 0;
        t = 0;
`endif
        return r;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] eff, input int last);
        for (int k = 1; k <= N; k++) begin
            if (eff[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    // Observation helpers: count negedges until grant/ack rises; -1 on timeout.
    task automatic wait_grant(input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget && n < 0; c++) begin
            @(negedge clk);
            if (grant != '0) n = c;
        end
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget && n < 0; c++) begin
            @(negedge clk);
            if (ack != '0) n = c;
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        req    = '1;
        bin_in = N*B'($urandom);
        repeat (3) @(negedge clk);
        n_checks++; if (grant !== '0) begin n_errors++; $display("FAIL reset_grant got=%b want=0", grant); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (ack !== '0) begin n_errors++; $display("FAIL reset_ack got=%b want=0", ack); end
        n_checks++; if (bcd_out !== '0) begin n_errors++; $display("FAIL reset_bcd got=%h want=0", bcd_out); end
        rst_n = 1'b1;
        req   = '0;
        model_last = N - 1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int r, v, n;
        logic [N-1:0] eg;
        for (int t = 0; t < 8; t++) begin
            r = (t < 2) ? 0 : int'($urandom_range(N - 1));
            v = (t == 0) ? 4095 : (t == 1) ? 999 : int'($urandom_range((1 << B) - 1));
            bin_in[r*B +: B] = B'(v);
            req = '0;
            req[r] = 1'b1;
            eg = oh(rr_pick(req, model_last));
            model_last = r;
            wait_grant(4, n);
            n_checks++; if (n !== 1) begin n_errors++; $display("FAIL single_grant_lat got=%0d want=1", n); end
            n_checks++; if (grant !== eg) begin n_errors++; $display("FAIL single_grant got=%b want=%b", grant, eg); end
            n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy got=%b want=1", busy); end
            wait_ack(B + 4, n);
            n_checks++; if (n !== B + 1) begin n_errors++; $display("FAIL single_ack_lat got=%0d want=%0d", n, B + 1); end
            n_checks++; if (ack !== eg) begin n_errors++; $display("FAIL single_ack got=%b want=%b", ack, eg); end
            n_checks++; if (bcd_out !== model_bcd(v)) begin n_errors++; $display("FAIL single_bcd v=%0d got=%h want=%h", v, bcd_out, model_bcd(v)); end
            req = '0;
            @(negedge clk);
            n_checks++; if (ack !== '0 || busy !== 1'b0) begin n_errors++; $display("FAIL single_ack_pulse ack=%b busy=%b want 0/0", ack, busy); end
        end
    endtask

    task automatic test_contention;
        int vals[N];
        int idx, n;
        logic [N-1:0] prev_ack;
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < N; i++) begin
                vals[i] = (rnd == 0) ? ((i == 0) ? 123 : 987) : int'($urandom_range((1 << B) - 1));
                bin_in[i*B +: B] = B'(vals[i]);
            end
            req = '1;
            prev_ack = '0;
            for (int k = 0; k < 6; k++) begin
                idx = rr_pick(req & ~prev_ack, model_last);
                model_last = idx;
                wait_grant(4, n);
                n_checks++; if (n !== 1) begin n_errors++; $display("FAIL cont_grant_lat k=%0d got=%0d want=1", k, n); end
                n_checks++; if (grant !== oh(idx)) begin n_errors++; $display("FAIL cont_grant k=%0d got=%b want=%b", k, grant, oh(idx)); end
                wait_ack(B + 4, n);
                n_checks++; if (n !== B + 1) begin n_errors++; $display("FAIL cont_ack_lat k=%0d got=%0d want=%0d", k, n, B + 1); end
                n_checks++; if (ack !== oh(idx)) begin n_errors++; $display("FAIL cont_ack k=%0d got=%b want=%b", k, ack, oh(idx)); end
                n_checks++; if (bcd_out !== model_bcd(vals[idx])) begin n_errors++; $display("FAIL cont_bcd k=%0d got=%h want=%h", k, bcd_out, model_bcd(vals[idx])); end
                prev_ack = oh(idx);
                if (k == 5) req = '0;
            end
            @(negedge clk);
            n_checks++; if (grant !== '0) begin n_errors++; $display("FAIL cont_idle_grant got=%b want=0", grant); end
        end
    endtask

    task automatic test_mid_reset;
        int v0, n;
        bit saw;
        v0 = int'($urandom_range((1 << B) - 1));
        bin_in[0 +: B] = B'(v0);
        req = 2'b01;
        wait_grant(4, n);
        n_checks++; if (grant !== 2'b01) begin n_errors++; $display("FAIL mrst_grant got=%b want=01", grant); end
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (grant !== '0 || busy !== 1'b0) begin n_errors++; $display("FAIL mrst_gb grant=%b busy=%b want 0/0", grant, busy); end
        n_checks++; if (ack !== '0) begin n_errors++; $display("FAIL mrst_ack got=%b want=0", ack); end
        n_checks++; if (bcd_out !== '0) begin n_errors++; $display("FAIL mrst_bcd got=%h want=0", bcd_out); end
        model_last = N - 1;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack != '0) saw = 1'b1;
        end
        rst_n = 1'b1;
        req = '0;
        repeat (20) begin
            @(negedge clk);
            if (ack != '0 || grant != '0) saw = 1'b1;
        end
        n_checks++; if (saw !== 1'b0) begin n_errors++; $display("FAIL mrst_no_ack got=%b want=0", saw); end
        v0 = int'($urandom_range((1 << B) - 1));
        bin_in[0 +: B] = B'(v0);
        bin_in[B +: B] = B'(500);
        req = 2'b11;
        wait_grant(4, n);
        n_checks++; if (grant !== oh(rr_pick(2'b11, model_last))) begin n_errors++; $display("FAIL mrst_first_grant got=%b want=%b", grant, oh(rr_pick(2'b11, model_last))); end
        wait_ack(B + 4, n);
        n_checks++; if (bcd_out !== model_bcd(v0)) begin n_errors++; $display("FAIL mrst_bcd0 got=%h want=%h", bcd_out, model_bcd(v0)); end
        req = 2'b10;
        wait_grant(4, n);
        n_checks++; if (grant !== 2'b10) begin n_errors++; $display("FAIL mrst_grant1 got=%b want=10", grant); end
        wait_ack(B + 4, n);
        n_checks++; if (ack !== 2'b10 || bcd_out !== model_bcd(500)) begin n_errors++; $display("FAIL mrst_bcd1 ack=%b got=%h want=%h", ack, bcd_out, model_bcd(500)); end
        req = '0;
        model_last = 1;
        @(negedge clk);
    endtask

    task automatic test_blank;
        int n;
        logic [BW-1:0] e42, e0;
`ifdef BCD_SCHED_BLANK_EN
        e42 = 16'hFF42;
        e0  = 16'hFFF0;
`else
        e42 = 16'h0042;
        e0  = 16'h0000;
`endif
        bin_in[B +: B] = B'(42);
        req = 2'b10;
        wait_grant(4, n);
        wait_ack(B + 4, n);
        n_checks++; if (bcd_out !== e42) begin n_errors++; $display("FAIL blank_42 got=%h want=%h", bcd_out, e42); end
        req = '0;
        @(negedge clk);
        bin_in[B +: B] = '0;
        req = 2'b10;
        wait_grant(4, n);
        wait_ack(B + 4, n);
        n_checks++; if (bcd_out !== e0) begin n_errors++; $display("FAIL blank_0 got=%h want=%h", bcd_out, e0); end
        req = '0;
        model_last = 1;
        @(negedge clk);
    endtask

    task automatic test_early_release;
        int r, v, d, n;
        for (int t = 0; t < 4; t++) begin
            r = (t == 0) ? 0 : int'($urandom_range(N - 1));
            d = (t == 0) ? 2 : int'($urandom_range(B, 1));
            v = int'($urandom_range((1 << B) - 1));
            bin_in[r*B +: B] = B'(v);
            req = '0;
            req[r] = 1'b1;
            model_last = r;
            wait_grant(4, n);
            repeat (d) @(negedge clk);
            req = '0;
            n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL early_busy got=%b want=1", busy); end
            wait_ack(B + 4, n);
            n_checks++; if (n !== B + 1 - d) begin n_errors++; $display("FAIL early_ack_lat d=%0d got=%0d want=%0d", d, n, B + 1 - d); end
            n_checks++; if (ack !== oh(r) || bcd_out !== model_bcd(v)) begin n_errors++; $display("FAIL early_result ack=%b want=%b bcd=%h want=%h", ack, oh(r), bcd_out, model_bcd(v)); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_mid_reset();
        test_blank();
        test_early_release();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
